uart_rx_ctrl: RTL and testbench

- UART receive-side controller, the counterpart of the transmit engine.
- Synchronises the serial rx line, detects and validates the start bit, and samples 7 or 8 data bits LSB-first at mid-bit, plus optional parity and one stop bit.
- Presents the received byte with sticky status flags to the host read interface.
- The rxrdy flag and the error flags use set/reset semantics with set-dominant priority.

---
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl: UART receiver (7/8 data bits, optional parity, 1 stop bit)
// with sticky host flags. `RX_MAJORITY_EN selects 2-of-3 sampling. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] div,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             rd_clr,
  output logic [7:0]       data,
  output logic             rxrdy,
  output logic             perr,
  output logic             ferr,
  output logic             ovf
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_LOAD   = 3'd5;

  logic             sync1_q, rxs_q, rxs_prev_q;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shreg_q, data_q;
  logic             eight_q, pen_q, ohel_q, pbit_q, stop_q;
  logic             rxrdy_q, perr_q, ferr_q, ovf_q;
  logic             rxrdy_d, perr_d, ferr_d, ovf_d;
  logic             fall, div_ok, busy, strobe, bit_val, last_bit, frame_go;
  logic             start_ok, shift_en, par_en, stop_en, load_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // sync1_q already holds what rxs_q will be one clock later, so the three
  // votes cover strobe-1/strobe/strobe+1 without shifting the frame timing.
`ifdef RX_MAJORITY_EN
  assign bit_val = (rxs_prev_q & rxs_q) | (rxs_prev_q & sync1_q) | (rxs_q & sync1_q);
`else
  assign bit_val = rxs_q;
`endif

  assign fall     = rxs_prev_q & ~rxs_q;
  assign div_ok   = (div >= DIV_W'(4));
  assign frame_go = (state_q == S_IDLE) && fall && div_ok;
  assign busy     = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign strobe   = busy && (cnt_q == '0);
  assign last_bit = (bitcnt_q == {2'b11, eight_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_go) state_d = S_START;
      S_START:  if (strobe) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (strobe && last_bit) state_d = pen_q ? S_PARITY : S_STOP;
      S_PARITY: if (strobe) state_d = S_STOP;
      S_STOP:   if (strobe) state_d = S_LOAD;
      S_LOAD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_ok = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    load_en  = (state_q == S_LOAD);
    cnt_d    = cnt_q;
    if (frame_go) begin
      cnt_d = (div >> 1) - DIV_W'(1);
    end else if (busy) begin
      cnt_d    = strobe ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
      start_ok = strobe && (state_q == S_START) && !bit_val;
      shift_en = strobe && (state_q == S_DATA);
      par_en   = strobe && (state_q == S_PARITY);
      stop_en  = strobe && (state_q == S_STOP);
    end
  end

  // Set-dominant flags: a load coinciding with rd_clr leaves the flag set.
  always_comb begin
    rxrdy_d = load_en | (rxrdy_q & ~rd_clr);
    ferr_d  = (load_en & ~stop_q) | (ferr_q & ~rd_clr);
    perr_d  = (load_en & pen_q & (pbit_q != ((^shreg_q) ^ ohel_q))) | (perr_q & ~rd_clr);
    ovf_d   = (load_en & rxrdy_q) | (ovf_q & ~rd_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= '0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'h00;
      eight_q  <= 1'b0;
      pen_q    <= 1'b0;
      ohel_q   <= 1'b0;
      pbit_q   <= 1'b0;
      stop_q   <= 1'b1;
      data_q   <= 8'h00;
      rxrdy_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (frame_go) div_q <= div;
      if (start_ok) begin
        bitcnt_q <= 3'd0;
        shreg_q  <= 8'h00;
        eight_q  <= eight;
        pen_q    <= pen;
        ohel_q   <= ohel;
      end
      if (shift_en) begin
        shreg_q[bitcnt_q] <= bit_val;
        bitcnt_q          <= bitcnt_q + 3'd1;
      end
      if (par_en)  pbit_q <= bit_val;
      if (stop_en) stop_q <= bit_val;
      if (load_en) data_q <= shreg_q;
      rxrdy_q <= rxrdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data  = data_q;
  assign rxrdy = rxrdy_q;
  assign perr  = perr_q;
  assign ferr  = ferr_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] div = 16'd16;
  logic        eight = 1'b1;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic        rd_clr = 1'b0;
  logic [7:0]  data;
  logic        rxrdy, perr, ferr, ovf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cyc = 0;
  logic rxrdy_prev = 1'b0;
  logic [7:0] glitch_exp;

  uart_rx_ctrl #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .div(div), .eight(eight), .pen(pen),
    .ohel(ohel), .rd_clr(rd_clr), .data(data), .rxrdy(rxrdy), .perr(perr),
    .ferr(ferr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxrdy === 1'b1 && rxrdy_prev !== 1'b1) rise_cyc = cyc;
    rxrdy_prev = rxrdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 rd_clr = 1'b1;
    @(posedge clk); #1 rd_clr = 1'b0;
  endtask

  // Drives one frame with one bit per div clocks; c counts clocks from the start edge.
  task automatic send(input logic [7:0] d, input int nbits, input bit pb_en, input bit pb,
                      input bit sb, input int clr_at, input int glitch_at, input int abort_at);
    logic [11:0] fb;
    int nb;
    int per;
    per = int'(div);
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fb[1+i] = d[i];
    nb = 1 + nbits;
    if (pb_en) begin
      fb[nb] = pb;
      nb++;
    end
    fb[nb] = sb;
    nb++;
    for (int c = 0; c < nb * per + 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) t0 = cyc;
      if (c == abort_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        return;
      end
      rx = ((c / per) < nb) ? fb[c / per] : 1'b1;
      if (c == glitch_at) rx = 1'b0;
      rd_clr = (c == clr_at);
    end
    rd_clr = 1'b0;
  endtask

  initial begin
`ifdef RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFB;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_rxrdy", 32'(rxrdy), 32'h0);
    check("reset_perr", 32'(perr), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 8N1 0xA5 with latency measurement
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    @(negedge clk);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_rxrdy", 32'(rxrdy), 32'h1);
    check("a5_perr", 32'(perr), 32'h0);
    check("a5_ferr", 32'(ferr), 32'h0);
    check("a5_ovf", 32'(ovf), 32'h0);
    check("a5_latency", 32'(rise_cyc - t0), 32'd156);
    pulse_clr();
    @(negedge clk);
    check("a5_clr_rxrdy", 32'(rxrdy), 32'h0);
    check("a5_clr_data", 32'(data), 32'hA5);

    // 7E1: good parity then inverted parity
    eight = 1'b0; pen = 1'b1; ohel = 1'b0;
    send(8'h35, 7, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    @(negedge clk);
    check("par_ok_data", 32'(data), 32'h35);
    check("par_ok_perr", 32'(perr), 32'h0);
    send(8'h35, 7, 1'b1, 1'b1, 1'b1, -1, -1, -1);
    @(negedge clk);
    check("par_bad_data", 32'(data), 32'h35);
    check("par_bad_perr", 32'(perr), 32'h1);
    check("par_bad_ovf", 32'(ovf), 32'h1);
    pulse_clr();
    @(negedge clk);
    check("par_clr_perr", 32'(perr), 32'h0);
    check("par_clr_ovf", 32'(ovf), 32'h0);
    check("par_clr_rxrdy", 32'(rxrdy), 32'h0);

    // framing error, then a good frame keeps ferr sticky
    eight = 1'b1; pen = 1'b0;
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    @(negedge clk);
    check("fe_data", 32'(data), 32'h3C);
    check("fe_ferr", 32'(ferr), 32'h1);
    check("fe_rxrdy", 32'(rxrdy), 32'h1);
    send(8'h11, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    @(negedge clk);
    check("fe_next_data", 32'(data), 32'h11);
    check("fe_next_ferr", 32'(ferr), 32'h1);
    pulse_clr();
    @(negedge clk);
    check("fe_clr_ferr", 32'(ferr), 32'h0);

    // overrun with rd_clr landing exactly in the second load cycle
    send(8'h11, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    send(8'h22, 8, 1'b0, 1'b0, 1'b1, 155, -1, -1);
    @(negedge clk);
    check("ovf_data", 32'(data), 32'h22);
    check("ovf_rxrdy", 32'(rxrdy), 32'h1);
    check("ovf_ovf", 32'(ovf), 32'h1);
    pulse_clr();

    // false start: 5-clk low pulse
    @(posedge clk); #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("fs_rxrdy", 32'(rxrdy), 32'h0);
    check("fs_ferr", 32'(ferr), 32'h0);
    check("fs_data", 32'(data), 32'h22);

    // reset during data bit 4, then a clean frame
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, -1, 85);
    @(negedge clk);
    check("rst_mid_data", 32'(data), 32'h00);
    check("rst_mid_rxrdy", 32'(rxrdy), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    send(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    @(negedge clk);
    check("after_rst_data", 32'(data), 32'h5A);
    check("after_rst_rxrdy", 32'(rxrdy), 32'h1);
    check("after_rst_ferr", 32'(ferr), 32'h0);
    check("after_rst_ovf", 32'(ovf), 32'h0);
    pulse_clr();

    // div below the legal minimum: frame ignored
    div = 16'd3;
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    @(negedge clk);
    check("div3_rxrdy", 32'(rxrdy), 32'h0);
    check("div3_data", 32'(data), 32'h5A);
    div = 16'd16;
    repeat (10) @(posedge clk);

    // 1-clk glitch at the mid-bit of data bit 2
    send(8'hFF, 8, 1'b0, 1'b0, 1'b1, -1, 56, -1);
    @(negedge clk);
    check("glitch_data", 32'(data), 32'(glitch_exp));
    check("glitch_rxrdy", 32'(rxrdy), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
